// File: rtl/eh2_ifu_align_expand_if.sv
// Signal bundle between fetch, the parcel aligner and decode.
// Optional feature macro: EH2_ALIGN_PC_TRACK_EN adds flush_pc / instr_pc.
//   slave  : aligner view (consumes fetch packets, produces instructions)
//   master : environment view (fetch + decode side)
interface eh2_ifu_align_expand_if #(
    parameter int FETCH_W = 32
);
    logic               fetch_valid;
    logic               fetch_ready;
    logic [FETCH_W-1:0] fetch_data;
    logic               flush;
    logic               instr_valid;
    logic               instr_ready;
    logic [31:0]        instr;
    logic               instr_c;
    logic               instr_illegal;
`ifdef EH2_ALIGN_PC_TRACK_EN
    logic [31:1]        flush_pc;
    logic [31:1]        instr_pc;

    modport slave (
        input  fetch_valid, fetch_data, flush, instr_ready, flush_pc,
        output fetch_ready, instr_valid, instr, instr_c, instr_illegal, instr_pc
    );

    modport master (
        output fetch_valid, fetch_data, flush, instr_ready, flush_pc,
        input  fetch_ready, instr_valid, instr, instr_c, instr_illegal, instr_pc
    );
`else
    modport slave (
        input  fetch_valid, fetch_data, flush, instr_ready,
        output fetch_ready, instr_valid, instr, instr_c, instr_illegal
    );

    modport master (
        output fetch_valid, fetch_data, flush, instr_ready,
        input  fetch_ready, instr_valid, instr, instr_c, instr_illegal
    );
`endif
endinterface

// File: rtl/eh2_ifu_align_expand.sv
// Parcel aligner and RV32C expander sitting between fetch and decode.
// Fetch packets are written into a circular buffer of 16-bit parcels; one
// 16- or 32-bit instruction is extracted per cycle from the head, compressed
// forms are expanded to their base-ISA equivalents.
// Optional feature macro: EH2_ALIGN_PC_TRACK_EN (head PC tracking, adds
// flush_pc / instr_pc to the interface).
module eh2_ifu_align_expand #(
    parameter int FETCH_W     = 32,
    parameter int BUF_PARCELS = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    eh2_ifu_align_expand_if.slave bus
);
    localparam int PTR_W = $clog2(BUF_PARCELS);
    localparam int CNT_W = PTR_W + 1;
    localparam int NPAR  = FETCH_W / 16;

    localparam logic [CNT_W-1:0] NPAR_C  = CNT_W'(NPAR);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BUF_PARCELS);
    localparam logic [PTR_W-1:0] NPAR_P  = PTR_W'(NPAR);

    // RV32C expansion: returns {illegal, instr}; instr is 0 when illegal.
    // No F/D extension, so the floating-point load/store forms are illegal.
    function automatic logic [32:0] rvc_expand(input logic [15:0] p);
        logic [31:0] ins;
        logic        ill;
        logic [4:0]  rd;
        logic [4:0]  rs2;
        logic [4:0]  rdp;
        logic [4:0]  rs1p;
        logic [11:0] imm6_sx;
        logic [11:0] uimm;
        logic [11:1] joff;
        ins     = 32'h0000_0000;
        ill     = 1'b0;
        rd      = p[11:7];
        rs2     = p[6:2];
        rdp     = {2'b01, p[4:2]};
        rs1p    = {2'b01, p[9:7]};
        imm6_sx = {{6{p[12]}}, p[12], p[6:2]};
        uimm    = {5'b00000, p[5], p[12:10], p[6], 2'b00};
        joff    = {p[12], p[8], p[10:9], p[6], p[7], p[2], p[11], p[5:3]};
        case ({p[1:0], p[15:13]})
            5'b00_000: begin // c.addi4spn
                uimm = {2'b00, p[10:7], p[12:11], p[5], p[6], 2'b00};
                if (uimm == 12'h000) begin
                    ill = 1'b1;
                end else begin
                    ins = {uimm, 5'd2, 3'b000, rdp, 7'b0010011};
                end
            end
            5'b00_010: ins = {uimm, rs1p, 3'b010, rdp, 7'b0000011};                   // c.lw
            5'b00_110: ins = {uimm[11:5], rdp, rs1p, 3'b010, uimm[4:0], 7'b0100011};  // c.sw
            5'b01_000: ins = {imm6_sx, rd, 3'b000, rd, 7'b0010011};                   // c.addi / c.nop
            5'b01_001: ins = {joff[11], joff[10:1], joff[11], {8{joff[11]}}, 5'd1, 7'b1101111}; // c.jal
            5'b01_010: ins = {imm6_sx, 5'd0, 3'b000, rd, 7'b0010011};                 // c.li
            5'b01_011: begin
                if ({p[12], p[6:2]} == 6'd0) begin
                    ill = 1'b1;
                end else if (rd == 5'd2) begin // c.addi16sp
                    ins = {{2{p[12]}}, p[12], p[4:3], p[5], p[2], p[6], 4'b0000,
                           5'd2, 3'b000, 5'd2, 7'b0010011};
                end else begin                 // c.lui
                    ins = {{14{p[12]}}, p[12], p[6:2], rd, 7'b0110111};
                end
            end
            5'b01_100: begin
                case (p[11:10])
                    2'b00: begin // c.srli
                        if (p[12]) begin
                            ill = 1'b1;
                        end else begin
                            ins = {7'b0000000, p[6:2], rs1p, 3'b101, rs1p, 7'b0010011};
                        end
                    end
                    2'b01: begin // c.srai
                        if (p[12]) begin
                            ill = 1'b1;
                        end else begin
                            ins = {7'b0100000, p[6:2], rs1p, 3'b101, rs1p, 7'b0010011};
                        end
                    end
                    2'b10: ins = {imm6_sx, rs1p, 3'b111, rs1p, 7'b0010011};           // c.andi
                    default: begin
                        if (p[12]) begin
                            ill = 1'b1; // RV64-only subw/addw and reserved
                        end else begin
                            case (p[6:5])
                                2'b00:   ins = {7'b0100000, rdp, rs1p, 3'b000, rs1p, 7'b0110011};
                                2'b01:   ins = {7'b0000000, rdp, rs1p, 3'b100, rs1p, 7'b0110011};
                                2'b10:   ins = {7'b0000000, rdp, rs1p, 3'b110, rs1p, 7'b0110011};
                                default: ins = {7'b0000000, rdp, rs1p, 3'b111, rs1p, 7'b0110011};
                            endcase
                        end
                    end
                endcase
            end
            5'b01_101: ins = {joff[11], joff[10:1], joff[11], {8{joff[11]}}, 5'd0, 7'b1101111}; // c.j
            5'b01_110: ins = {{4{p[12]}}, p[6:5], p[2], 5'd0, rs1p, 3'b000,
                              p[11:10], p[4:3], p[12], 7'b1100011};                   // c.beqz
            5'b01_111: ins = {{4{p[12]}}, p[6:5], p[2], 5'd0, rs1p, 3'b001,
                              p[11:10], p[4:3], p[12], 7'b1100011};                   // c.bnez
            5'b10_000: begin // c.slli
                if (p[12]) begin
                    ill = 1'b1;
                end else begin
                    ins = {7'b0000000, p[6:2], rd, 3'b001, rd, 7'b0010011};
                end
            end
            5'b10_010: begin // c.lwsp
                if (rd == 5'd0) begin
                    ill = 1'b1;
                end else begin
                    ins = {4'b0000, p[3:2], p[12], p[6:4], 2'b00, 5'd2, 3'b010, rd, 7'b0000011};
                end
            end
            5'b10_100: begin
                if (!p[12]) begin
                    if (rs2 != 5'd0) begin
                        ins = {7'b0000000, rs2, 5'd0, 3'b000, rd, 7'b0110011};        // c.mv
                    end else if (rd != 5'd0) begin
                        ins = {12'h000, rd, 3'b000, 5'd0, 7'b1100111};                // c.jr
                    end else begin
                        ill = 1'b1;
                    end
                end else begin
                    if (rs2 != 5'd0) begin
                        ins = {7'b0000000, rs2, rd, 3'b000, rd, 7'b0110011};          // c.add
                    end else if (rd != 5'd0) begin
                        ins = {12'h000, rd, 3'b000, 5'd1, 7'b1100111};                // c.jalr
                    end else begin
                        ins = 32'h0010_0073;                                          // c.ebreak
                    end
                end
            end
            5'b10_110: begin // c.swsp
                uimm = {4'b0000, p[8:7], p[12:9], 2'b00};
                ins  = {uimm[11:5], rs2, 5'd2, 3'b010, uimm[4:0], 7'b0100011};
            end
            default: ill = 1'b1;
        endcase
        if (ill) begin
            ins = 32'h0000_0000;
        end else begin
            ins = ins;
        end
        return {ill, ins};
    endfunction

    logic [15:0]      buf_q [BUF_PARCELS];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [15:0]      p0_s;
    logic [15:0]      p1_s;
    logic             is32_s;
    logic [32:0]      exp_s;
    logic             fetch_ready_s;
    logic             instr_valid_s;
    logic [31:0]      instr_s;
    logic             instr_c_s;
    logic             instr_illegal_s;
    logic             push_s;
    logic             pop_s;
    logic [CNT_W-1:0] push_cnt_s;
    logic [CNT_W-1:0] pop_cnt_s;

    assign p0_s   = buf_q[rd_ptr_q];
    assign p1_s   = buf_q[rd_ptr_q + PTR_W'(1)];
    assign is32_s = (p0_s[1:0] == 2'b11);
    assign exp_s  = rvc_expand(p0_s);

    // Push is gated on registered occupancy only; flush drops a concurrent push.
    assign fetch_ready_s = !rst && ((DEPTH_C - count_q) >= NPAR_C);
    assign push_s        = bus.fetch_valid && fetch_ready_s && !bus.flush;
    assign pop_s         = instr_valid_s && bus.instr_ready && !bus.flush;
    assign push_cnt_s    = push_s ? NPAR_C : CNT_W'(0);

    // Head decode: present the instruction at rd_ptr once all its parcels are in.
    always_comb begin
        instr_valid_s   = 1'b0;
        instr_s         = 32'h0000_0000;
        instr_c_s       = 1'b0;
        instr_illegal_s = 1'b0;
        if (rst) begin
            instr_valid_s = 1'b0;
        end else if (is32_s) begin
            instr_valid_s = (count_q >= CNT_W'(2));
            if (instr_valid_s) begin
                instr_s = {p1_s, p0_s};
            end else begin
                instr_s = 32'h0000_0000;
            end
        end else begin
            instr_valid_s = (count_q >= CNT_W'(1));
            if (instr_valid_s) begin
                instr_s         = exp_s[31:0];
                instr_c_s       = 1'b1;
                instr_illegal_s = exp_s[32];
            end else begin
                instr_c_s = 1'b0;
            end
        end
    end

    assign pop_cnt_s = !pop_s ? CNT_W'(0) : (instr_c_s ? CNT_W'(1) : CNT_W'(2));

    // Next-state for pointers and occupancy; flush has priority over push/pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (bus.flush) begin
            rd_ptr_d = wr_ptr_q;
            count_d  = CNT_W'(0);
        end else begin
            if (push_s) begin
                wr_ptr_d = wr_ptr_q + NPAR_P;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            rd_ptr_d = rd_ptr_q + pop_cnt_s[PTR_W-1:0];
            count_d  = count_q + push_cnt_s - pop_cnt_s;
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Parcel storage write; contents need no reset since count guards every read.
    always_ff @(posedge clk) begin
        if (push_s) begin
            for (int i = 0; i < NPAR; i++) begin
                buf_q[wr_ptr_q + PTR_W'(i)] <= bus.fetch_data[16*i +: 16];
            end
        end
    end

    assign bus.fetch_ready   = fetch_ready_s;
    assign bus.instr_valid   = instr_valid_s;
    assign bus.instr         = instr_s;
    assign bus.instr_c       = instr_c_s;
    assign bus.instr_illegal = instr_illegal_s;

`ifdef EH2_ALIGN_PC_TRACK_EN
    logic [31:1] pc_q, pc_d;

    // Head PC next-state: reload on redirect, advance by instruction size on pop.
    always_comb begin
        pc_d = pc_q;
        if (bus.flush) begin
            pc_d = bus.flush_pc;
        end else if (pop_s) begin
            pc_d = pc_q + 31'(pop_cnt_s);
        end else begin
            pc_d = pc_q;
        end
    end

    // Head PC register.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= 31'h0;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign bus.instr_pc = instr_valid_s ? pc_q : 31'h0;
`endif

endmodule
